// File: rtl/text_writer.sv
// Cursor-managed writer into the 32x32 text buffer; handles CR, LF, BS and FF.
// Define TEXT_WRITER_SCROLL_EN to scroll via top_row / o_offset_y instead of wrapping.
module text_writer #(
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic        i_pix_clk,
  input  logic        i_reset_n,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  output logic        o_ready,
  output logic        o_wr_en,
  output logic [9:0]  o_wr_addr,
  output logic [7:0]  o_wr_data,
  output logic [4:0]  o_cursor_row,
  output logic [4:0]  o_cursor_col,
  output logic [15:0] o_offset_y,
  output logic        o_busy
);

  localparam logic [7:0] CODE_LF = 8'h0A;
  localparam logic [7:0] CODE_CR = 8'h0D;
  localparam logic [7:0] CODE_BS = 8'h08;
  localparam logic [7:0] CODE_FF = 8'h0C;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR_ROW,
    CLEAR_ALL
  } state_t;

  state_t     state;
  logic [4:0] row;
  logic [4:0] col;
  logic [4:0] top_row;
  logic [9:0] clr_cnt;
  logic       clr_last;

  logic       accept;
  logic       is_glyph;
  logic       do_advance;
  logic       scroll_hit;
  logic [4:0] row_inc;

  always_comb begin
    accept     = 1'b0;
    is_glyph   = 1'b0;
    do_advance = 1'b0;
    scroll_hit = 1'b0;
    row_inc    = row + 5'd1;
    accept     = (state == IDLE) && i_valid && o_ready;
    is_glyph   = (i_data != CODE_LF) && (i_data != CODE_CR) &&
                 (i_data != CODE_BS) && (i_data != CODE_FF);
    // A glyph in the last column carries an implicit line feed.
    do_advance = accept && ((i_data == CODE_LF) || (is_glyph && (col == 5'd31)));
`ifdef TEXT_WRITER_SCROLL_EN
    scroll_hit = (row_inc == top_row);
`else
    scroll_hit = 1'b0;
`endif
  end

  always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      top_row   <= '0;
      clr_cnt   <= '0;
      clr_last  <= 1'b0;
      o_ready   <= 1'b1;
      o_busy    <= 1'b0;
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
    end else begin
      o_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_glyph) begin
              o_wr_en   <= 1'b1;
              o_wr_addr <= {row, col};
              o_wr_data <= i_data;
              col       <= col + 5'd1;
            end else if (i_data == CODE_CR) begin
              col <= '0;
            end else if (i_data == CODE_BS) begin
              if (col != 5'd0) begin
                o_wr_en   <= 1'b1;
                o_wr_addr <= {row, col - 5'd1};
                o_wr_data <= BLANK_CHAR;
                col       <= col - 5'd1;
              end
            end else if (i_data == CODE_FF) begin
              state    <= CLEAR_ALL;
              o_ready  <= 1'b0;
              o_busy   <= 1'b1;
              clr_cnt  <= '0;
              clr_last <= 1'b0;
            end
          end
          if (do_advance) begin
            row <= row_inc;
            if (scroll_hit) begin
              top_row  <= top_row + 5'd1;
              state    <= CLEAR_ROW;
              o_ready  <= 1'b0;
              o_busy   <= 1'b1;
              clr_cnt  <= '0;
              clr_last <= 1'b0;
            end
          end
        end

        // Clears issue one write per cycle; the extra clr_last cycle holds
        // o_ready low until the cycle after the final write.
        CLEAR_ROW: begin
          if (clr_last) begin
            state   <= IDLE;
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
          end else begin
            o_wr_en   <= 1'b1;
            o_wr_addr <= {row, clr_cnt[4:0]};
            o_wr_data <= BLANK_CHAR;
            clr_cnt   <= clr_cnt + 10'd1;
            clr_last  <= (clr_cnt[4:0] == 5'd31);
          end
        end

        CLEAR_ALL: begin
          if (clr_last) begin
            state   <= IDLE;
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
            row     <= '0;
            col     <= '0;
            top_row <= '0;
          end else begin
            o_wr_en   <= 1'b1;
            o_wr_addr <= clr_cnt;
            o_wr_data <= BLANK_CHAR;
            clr_cnt   <= clr_cnt + 10'd1;
            clr_last  <= (clr_cnt == 10'd1023);
          end
        end

        default: begin
          state   <= IDLE;
          o_ready <= 1'b1;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_cursor_row = row;
  assign o_cursor_col = col;
  assign o_offset_y   = {8'h00, top_row, 3'b000};

endmodule

// File: tb/tb_text_writer.sv
// Scoreboard bench for text_writer: expected writes queued by stimulus, popped by a monitor.
module tb_text_writer;

  logic        i_pix_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_valid   = 1'b0;
  logic [7:0]  i_data    = 8'h00;
  logic        o_ready;
  logic        o_wr_en;
  logic [9:0]  o_wr_addr;
  logic [7:0]  o_wr_data;
  logic [4:0]  o_cursor_row;
  logic [4:0]  o_cursor_col;
  logic [15:0] o_offset_y;
  logic        o_busy;

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];

  text_writer #(.BLANK_CHAR(8'h20)) dut (
    .i_pix_clk    (i_pix_clk),
    .i_reset_n    (i_reset_n),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_ready      (o_ready),
    .o_wr_en      (o_wr_en),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_cursor_row (o_cursor_row),
    .o_cursor_col (o_cursor_col),
    .o_offset_y   (o_offset_y),
    .o_busy       (o_busy)
  );

  always #5 i_pix_clk = ~i_pix_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [9:0] addr, input logic [7:0] data);
    exp_q.push_back({addr, data});
  endtask

  // Waits for o_ready at a falling edge, then presents the byte for one rising edge.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge i_pix_clk);
    while (!o_ready && n < 3000) begin
      @(negedge i_pix_clk);
      n++;
    end
    if (!o_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: o_ready still %0b after %0d cycles", o_ready, n);
    end
    i_valid = 1'b1;
    i_data  = b;
    @(posedge i_pix_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_ready"}, o_ready, 1);
    chk({tag, "_wr_en"}, o_wr_en, 0);
    chk({tag, "_wr_addr"}, o_wr_addr, 0);
    chk({tag, "_wr_data"}, o_wr_data, 0);
    chk({tag, "_row"}, o_cursor_row, 0);
    chk({tag, "_col"}, o_cursor_col, 0);
    chk({tag, "_offset"}, o_offset_y, 0);
    chk({tag, "_busy"}, o_busy, 0);
  endtask

  always @(negedge i_pix_clk) begin
    if (i_reset_n && o_wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h with empty queue", o_wr_addr, o_wr_data);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", {22'd0, o_wr_addr}, {22'd0, e[17:8]});
        chk("wr_data", {24'd0, o_wr_data}, {24'd0, e[7:0]});
      end
    end
  end

  initial begin
    int nready;
    int busy_bad;

    repeat (3) @(negedge i_pix_clk);
    chk_reset_values("rst");
    i_reset_n = 1'b1;

    // Back-to-back glyphs
    expect_wr(10'd0, 8'h48);
    expect_wr(10'd1, 8'h69);
    send(8'h48);
    chk("ready_after_H", o_ready, 1);
    send(8'h69);
    chk("col_after_Hi", o_cursor_col, 2);
    chk("ready_after_Hi", o_ready, 1);

    // Move to col 5, backspace, then backspace at col 0
    expect_wr(10'd2, 8'h61);
    expect_wr(10'd3, 8'h62);
    expect_wr(10'd4, 8'h63);
    send(8'h61);
    send(8'h62);
    send(8'h63);
    chk("col_before_bs", o_cursor_col, 5);
    expect_wr(10'd4, 8'h20);
    send(8'h08);
    chk("col_after_bs", o_cursor_col, 4);
    send(8'h0D);
    chk("col_after_cr", o_cursor_col, 0);
    send(8'h08);
    chk("bs_col0_col", o_cursor_col, 0);
    chk("bs_col0_row", o_cursor_row, 0);
    repeat (2) @(negedge i_pix_clk);
    chk("bs_col0_no_write", exp_q.size(), 0);

    // 32 glyphs on row 0 wrap to row 1
    for (int i = 0; i < 32; i++) expect_wr(10'(i), 8'(8'h30 + i));
    for (int i = 0; i < 32; i++) send(8'(8'h30 + i));
    chk("wrap_row", o_cursor_row, 1);
    chk("wrap_col", o_cursor_col, 0);
    send(8'h0D);
    send(8'h0A);
    chk("crlf_row", o_cursor_row, 2);
    chk("crlf_col", o_cursor_col, 0);
    chk("crlf_ready", o_ready, 1);

    // Full clear
    for (int i = 0; i < 1024; i++) expect_wr(10'(i), 8'h20);
    send(8'h0C);
    nready   = 0;
    busy_bad = 0;
    forever begin
      @(negedge i_pix_clk);
      if (o_ready || nready > 2000) break;
      nready++;
      if (!o_busy) busy_bad++;
    end
    chk("ff_not_ready_cycles", nready, 1025);
    chk("ff_busy_gaps", busy_bad, 0);
    chk("ff_busy_end", o_busy, 0);
    chk("ff_row", o_cursor_row, 0);
    chk("ff_col", o_cursor_col, 0);
    chk("ff_offset", o_offset_y, 0);
    chk("ff_queue_drained", exp_q.size(), 0);

    // 32 line feeds from row 0
    for (int i = 0; i < 31; i++) send(8'h0A);
    chk("lf31_row", o_cursor_row, 31);
`ifdef TEXT_WRITER_SCROLL_EN
    for (int i = 0; i < 32; i++) expect_wr(10'(i), 8'h20);
    send(8'h0A);
    chk("lf32_row", o_cursor_row, 0);
    chk("lf32_offset", o_offset_y, 16'h0008);
    chk("lf32_ready", o_ready, 0);
    chk("lf32_busy", o_busy, 1);
    nready = 0;
    forever begin
      @(negedge i_pix_clk);
      if (o_ready || nready > 200) break;
      nready++;
    end
    chk("clear_row_not_ready_cycles", nready, 33);
`else
    send(8'h0A);
    chk("lf32_row", o_cursor_row, 0);
    chk("lf32_offset", o_offset_y, 0);
    chk("lf32_ready", o_ready, 1);
    chk("lf32_busy", o_busy, 0);
`endif
    repeat (3) @(negedge i_pix_clk);
    chk("lf_queue_drained", exp_q.size(), 0);

    // Reset in the middle of a full clear
    for (int i = 0; i < 1024; i++) expect_wr(10'(i), 8'h20);
    send(8'h0C);
    repeat (100) @(negedge i_pix_clk);
    #2;
    i_reset_n = 1'b0;
    #1;
    chk_reset_values("midclr");
    exp_q.delete();
    repeat (2) @(negedge i_pix_clk);
    i_reset_n = 1'b1;
    expect_wr(10'd0, 8'h41);
    send(8'h41);
    chk("post_reset_col", o_cursor_col, 1);
    chk("post_reset_ready", o_ready, 1);

    repeat (4) @(negedge i_pix_clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
